logic_arbiter: RTL and testbench
================================

LOGIC_ARBITER -- requirements
Module: logic_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  operation accepted this cycle when valid and ready are both high.
REQ-006 SHALL have ports req0_op / req1_op  input  3  opcode: 0 AND, 1 OR, 2 NOT(A), 3 XOR, 4 NOR, 5-7 illegal.
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  DATA_WIDTH  operands.
REQ-008 SHALL have port rsp_valid  output  1  result register holds an undelivered result.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts the result this cycle.
REQ-010 SHALL have port rsp_id  output  1  requester index that owns the result.
REQ-011 SHALL have port rsp_data  output  DATA_WIDTH  registered logic result.
REQ-012 SHALL have port rsp_err  output  1  high with rsp_valid when the opcode was illegal.

Function
REQ-013 SHALL share one logic unit between two requesters; at most one operation is accepted per cycle.
REQ-014 SHALL use a two-state FSM: IDLE (result register empty) and HOLD (result register full).
REQ-015 SHALL define slot_free = (state==IDLE) or rsp_ready; grant is possible only when slot_free is high.
REQ-016 SHALL assert at most one of req0_ready/req1_ready per cycle, driven combinationally from valids, slot_free and the priority pointer.
REQ-017 SHALL assert reqN_ready only while reqN_valid is high and the grant goes to N; ready is never asserted for an idle requester.
REQ-018 SHALL on a grant capture the result, owner id and error flag into the result register at the next rising edge; latency from acceptance to rsp_valid is 1 cycle.
REQ-019 SHALL transition IDLE->HOLD on grant; HOLD->IDLE on rsp_ready without a new grant; HOLD->HOLD on rsp_ready with a simultaneous grant (back-to-back, zero bubble).
REQ-020 SHALL hold rsp_data, rsp_id and rsp_err stable while rsp_valid is high and rsp_ready is low.
REQ-021 SHALL on an illegal opcode (5-7) produce rsp_data = 0 and rsp_err = 1; the operation still consumes one grant.
REQ-022 SHALL treat NOT as a function of A only; B is ignored.
REQ-023 SHALL perform every operation bitwise over the full DATA_WIDTH with no carries and no truncation.
REQ-024 SHALL grant the single valid requester when only one requester is valid, independent of the pointer.

Reset
REQ-025 SHALL, with rst high at a rising edge, set state to IDLE, rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_err = 0 and the priority pointer to requester 0.
REQ-026 SHALL, with rst high, force req0_ready = req1_ready = 0 in the same cycle; any in-flight result is discarded with no response delivered.

Configuration
REQ-027 SHALL support macro LOGIC_ARB_RR_EN: when defined, on simultaneous valids the grant goes to the pointer side and the pointer moves to the other requester after every grant; when undefined, requester 0 always wins and no pointer register exists.

Structure
REQ-028 SHALL place the opcode encodings, the FSM state encoding and the opcode width constant in shared package logic_pkg.
REQ-029 SHALL instantiate one combinational sub-module logic_unit (inputs op, A, B; outputs result, illegal) selected by the muxed requester operands.

Verification
REQ-030 SHALL cover: req0 op=0 A=0xF0F0F0F0 B=0xFF00FF00, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=0xF000F000, rsp_err=0.
REQ-031 SHALL cover: both valid every cycle, ops 3 (req0) and 4 (req1), A=0xAAAAAAAA B=0x0000FFFF -> with LOGIC_ARB_RR_EN ids alternate 0,1,0,1 with data 0xAAAA5555 / 0x55550000; without it only id 0 is served.
REQ-032 SHALL cover: rsp_ready=0 for 3 cycles after a result -> rsp_* stable, both reqN_ready=0; rsp_ready=1 with req1 valid -> same-cycle grant, rsp_valid stays high, rsp_id=1 next cycle.
REQ-033 SHALL cover: req1 op=6 -> rsp_data=0, rsp_err=1, rsp_id=1.
REQ-034 SHALL cover: rst asserted while state=HOLD -> next cycle rsp_valid=0, rsp_data=0, readies low; after release req0 op=2 A=0 -> rsp_data=0xFFFFFFFF.

Source files
------------

// File: rtl/logic_pkg.sv
// Shared opcode encodings, opcode width and FSM state encoding for logic_arbiter.
package logic_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND = 3'd0,
        OP_OR  = 3'd1,
        OP_NOT = 3'd2,
        OP_XOR = 3'd3,
        OP_NOR = 3'd4
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise logic unit; opcodes 5-7 yield zero with illegal raised.
module logic_unit
    import logic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [OP_W-1:0]       op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  illegal
);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NOT:  result = ~a;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/logic_arbiter.sv
// Two-requester arbiter sharing one logic_unit behind a single result register.
// Define LOGIC_ARB_RR_EN for round-robin on contention; otherwise requester 0 wins.
module logic_arbiter
    import logic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [OP_W-1:0]       req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [OP_W-1:0]       req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_id_q, rsp_id_d;
    logic                  rsp_err_q, rsp_err_d;

    logic                  slot_free;
    logic                  gnt0, gnt1, grant;
    logic [OP_W-1:0]       op_sel;
    logic [DATA_WIDTH-1:0] a_sel, b_sel, lu_result;
    logic                  lu_illegal;

`ifdef LOGIC_ARB_RR_EN
    logic ptr_q, ptr_d;
`endif

    assign slot_free = (state_q == ST_IDLE) || rsp_ready;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && slot_free) begin
            if (req0_valid && req1_valid) begin
`ifdef LOGIC_ARB_RR_EN
                if (ptr_q) gnt1 = 1'b1;
                else       gnt0 = 1'b1;
`else
                gnt0 = 1'b1;
`endif
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign grant      = gnt0 | gnt1;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    assign op_sel = gnt1 ? req1_op : req0_op;
    assign a_sel  = gnt1 ? req1_a  : req0_a;
    assign b_sel  = gnt1 ? req1_b  : req0_b;

    logic_unit #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_logic_unit (
        .op      (op_sel),
        .a       (a_sel),
        .b       (b_sel),
        .result  (lu_result),
        .illegal (lu_illegal)
    );

    // A grant while HOLD overwrites the register in the same edge it is drained.
    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rsp_err_d  = rsp_err_q;
        if (grant) begin
            state_d    = ST_HOLD;
            rsp_data_d = lu_result;
            rsp_id_d   = gnt1;
            rsp_err_d  = lu_illegal;
        end else if (state_q == ST_HOLD && rsp_ready) begin
            state_d = ST_IDLE;
        end
    end

`ifdef LOGIC_ARB_RR_EN
    always_comb begin
        ptr_d = ptr_q;
        if (grant) ptr_d = ~gnt1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

`ifdef LOGIC_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end
`endif

    assign rsp_valid = (state_q == ST_HOLD);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_logic_arbiter.sv
// Scoreboard bench for logic_arbiter: accepted requests push hand-computed
// responses; a monitor pops and compares on every delivered result.
module tb_logic_arbiter;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    logic [2:0]    req0_op, req1_op;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [DW-1:0] rsp_data;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        logic          err;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every completed response handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id=%0d data=0x%08h with empty scoreboard", rsp_id, rsp_data);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("rsp_id",   {31'd0, rsp_id},  {31'd0, e.id});
                chk("rsp_data", rsp_data,         e.data);
                chk("rsp_err",  {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the grant pattern at mid-cycle, records the expected response, advances one cycle.
    task automatic expect_grant(input int id, input logic [DW-1:0] data, input logic err);
        rsp_t e;
        @(negedge clk);
        chk("req0_ready", {31'd0, req0_ready}, {31'd0, (id == 0)});
        chk("req1_ready", {31'd0, req1_ready}, {31'd0, (id == 1)});
        e.id = (id == 1);
        e.data = data;
        e.err = err;
        exp_q.push_back(e);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = '1; req0_b = '1;
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = '1; req1_b = '1;
        step(); step();
        @(negedge clk);
        chk("reset_rsp_valid",  {31'd0, rsp_valid},  32'd0);
        chk("reset_rsp_data",   rsp_data,            32'd0);
        chk("reset_rsp_id",     {31'd0, rsp_id},     32'd0);
        chk("reset_rsp_err",    {31'd0, rsp_err},    32'd0);
        chk("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("reset_req1_ready", {31'd0, req1_ready}, 32'd0);
        step();
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        step();

        // AND from requester 0
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'hF0F0F0F0; req0_b = 32'hFF00FF00;
        expect_grant(0, 32'hF000F000, 1'b0);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("lat1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        step();

        // Illegal opcode from requester 1
        req1_valid = 1'b1; req1_op = 3'd6; req1_a = 32'hFFFFFFFF; req1_b = 32'hFFFFFFFF;
        expect_grant(1, 32'h0, 1'b1);
        req1_valid = 1'b0;
        step();

        // Contention: XOR on req0, NOR on req1 every cycle
        req0_valid = 1'b1; req0_op = 3'd3; req0_a = 32'hAAAAAAAA; req0_b = 32'h0000FFFF;
        req1_valid = 1'b1; req1_op = 3'd4; req1_a = 32'hAAAAAAAA; req1_b = 32'h0000FFFF;
`ifdef LOGIC_ARB_RR_EN
        expect_grant(0, 32'hAAAA5555, 1'b0);
        expect_grant(1, 32'h55550000, 1'b0);
        expect_grant(0, 32'hAAAA5555, 1'b0);
        expect_grant(1, 32'h55550000, 1'b0);
`else
        for (int i = 0; i < 4; i++) expect_grant(0, 32'hAAAA5555, 1'b0);
`endif
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Backpressure: result held for 3 cycles, then back-to-back grant to req1
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd1; req0_a = 32'h12345678; req0_b = 32'h0F0F0000;
        expect_grant(0, 32'h1F3F5678, 1'b0);
        req1_valid = 1'b1; req1_op = 3'd0; req1_a = 32'hFFFF0000; req1_b = 32'h0F0F0F0F;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid",  {31'd0, rsp_valid},  32'd1);
            chk("hold_rsp_data",   rsp_data,            32'h1F3F5678);
            chk("hold_rsp_id",     {31'd0, rsp_id},     32'd0);
            chk("hold_rsp_err",    {31'd0, rsp_err},    32'd0);
            chk("hold_req0_ready", {31'd0, req0_ready}, 32'd0);
            chk("hold_req1_ready", {31'd0, req1_ready}, 32'd0);
            step();
        end
        req0_valid = 1'b0; rsp_ready = 1'b1;
        expect_grant(1, 32'h0F0F0000, 1'b0);
        req1_valid = 1'b0;
        @(negedge clk);
        chk("b2b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("b2b_rsp_id",    {31'd0, rsp_id},    32'd1);
        step();

        // Reset while holding a result discards it
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 32'h1; req0_b = 32'h1;
        expect_grant(0, 32'h1, 1'b0);
        rst = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
        exp_q.delete();
        step();
        @(negedge clk);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data",  rsp_data,           32'd0);
        step();
        rst = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 32'h0; req0_b = 32'h12345678;
        expect_grant(0, 32'hFFFFFFFF, 1'b0);
        req0_valid = 1'b0;
        step(); step();

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
